// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// Registered output stage plus a one-entry skid buffer. Generic payload;
// it has no knowledge of PCs or redirects, only valid/ready and a clear.
module fetch_skid_buf #(
  parameter int W = 41
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         skid_valid
);

  logic         out_v_q, out_v_d;
  logic         skid_v_q, skid_v_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         xfer;
  logic         accept;

  assign in_ready   = !skid_v_q;
  assign out_valid  = out_v_q;
  assign out_data   = out_data_q;
  assign skid_valid = skid_v_q;

  assign xfer   = out_v_q && out_ready;
  assign accept = in_valid && in_ready;

  always_comb begin
    // NOTE: every _d gets its current value first so no path leaves it unassigned (no latch).
    out_v_d     = out_v_q;
    skid_v_d    = skid_v_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;

    if (clear) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (xfer) begin
      // The skid entry is older than anything arriving, so it goes out first.
      if (skid_v_q) begin
        out_data_d = skid_data_q;
        skid_v_d   = 1'b0;
      end else if (accept) begin
        out_data_d = in_data;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (accept) begin
      if (out_v_q) begin
        skid_data_d = in_data;
        skid_v_d    = 1'b1;
      end else begin
        out_data_d = in_data;
        out_v_d    = 1'b1;
      end
    end
  end

  // NOTE: the data registers are reset too, so the output port reads zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      out_v_q     <= 1'b0;
      skid_v_q    <= 1'b0;
      out_data_q  <= '0;
      skid_data_q <= '0;
    end else begin
      out_v_q     <= out_v_d;
      skid_v_q    <= skid_v_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch front end: PC register, synchronous imem requests, redirect flush.
// Optional saturating redirect counter when FETCH_REDIRECT_CNT_EN is defined.
module fetch_redirect_unit
  import fetch_pkg::*;
#(
  parameter int          PC_W     = 9,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_sel,
  input  logic [31:0]     br_pc,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [PC_W-1:0] if_pc,
  output logic [31:0]     if_pc_four,
  output logic [31:0]     if_instr,
`ifdef FETCH_REDIRECT_CNT_EN
  output logic [15:0]     redirect_cnt,
`endif
  output logic            flush
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_v_q, inflight_v_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;

  fetch_entry_t    ret_entry;
  fetch_entry_t    out_entry;
  logic            out_v;
  logic            skid_v;
  logic            buf_in_ready;
  logic            xfer;
  logic [1:0]      occupancy;
  logic            credit_ok;
  logic            req;
  logic            unused_ok;

  assign unused_ok = ^{br_pc[31:PC_W], br_pc[1:0], buf_in_ready};

  assign xfer      = out_v && if_ready;
  assign occupancy = 2'(out_v) + 2'(skid_v) + 2'(inflight_v_q);
  // At most one entry may remain buffered once this cycle's transfer leaves.
  assign credit_ok = occupancy <= (2'd1 + 2'(xfer));
  assign req       = (state_q == RUN) && credit_ok && !pc_sel;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_v_d  = 1'b0;
    inflight_pc_d = inflight_pc_q;

    if (pc_sel) begin
      state_d    = RUN;
      fetch_pc_d = {br_pc[PC_W-1:2], 2'b00};
    end else if (state_q == BOOT) begin
      state_d = RUN;
    end else if (req) begin
      inflight_v_d  = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + PC_W'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      fetch_pc_q    <= PC_W'(RESET_PC);
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign ret_entry.pc    = inflight_pc_q;
  assign ret_entry.instr = imem_rdata;

  fetch_skid_buf #(
    .W($bits(fetch_entry_t))
  ) u_skid_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (pc_sel),
    .in_valid  (inflight_v_q),
    .in_ready  (buf_in_ready),
    .in_data   (ret_entry),
    .out_valid (out_v),
    .out_ready (if_ready),
    .out_data  (out_entry),
    .skid_valid(skid_v)
  );

  assign imem_addr  = fetch_pc_q;
  assign if_valid   = out_v;
  assign if_pc      = out_entry.pc;
  assign if_instr   = out_entry.instr;
  assign if_pc_four = 32'(out_entry.pc) + 32'(INSTR_BYTES);
  assign flush      = pc_sel;

`ifdef FETCH_REDIRECT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pc_sel && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign redirect_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: scoreboard of expected PCs
// consumed on each decode-side transfer, plus per-scenario timing checks.
module tb_fetch_redirect_unit;

  localparam int PC_W = 9;

  logic            clk = 1'b0;
  logic            reset;
  logic            pc_sel;
  logic [31:0]     br_pc;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [PC_W-1:0] if_pc;
  logic [31:0]     if_pc_four;
  logic [31:0]     if_instr;
  logic            flush;
`ifdef FETCH_REDIRECT_CNT_EN
  logic [15:0]     redirect_cnt;
`endif

  logic [31:0]     mem [128];
  logic [PC_W-1:0] sb [$];
  int              vecs = 0;
  int              errs = 0;

  fetch_redirect_unit #(
    .PC_W    (PC_W),
    .RESET_PC(0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_sel      (pc_sel),
    .br_pc       (br_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_pc_four  (if_pc_four),
    .if_instr    (if_instr),
`ifdef FETCH_REDIRECT_CNT_EN
    .redirect_cnt(redirect_cnt),
`endif
    .flush       (flush)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
  end

  always @(posedge clk) imem_rdata <= mem[imem_addr[PC_W-1:2]];

  // Advance one cycle; at the mid-cycle sample, retire any transfer against the scoreboard.
  task automatic cycle();
    logic [PC_W-1:0] exp_pc;
    @(negedge clk);
    if (!reset && if_valid && if_ready) begin
      vecs++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL sb_unexpected: got pc %h, want no transfer", if_pc);
      end else begin
        exp_pc = sb.pop_front();
        if (if_pc !== exp_pc) begin
          errs++;
          $display("FAIL sb_pc: got %h want %h", if_pc, exp_pc);
        end
        vecs++;
        if (if_instr !== 32'h1000_0000 + 32'(exp_pc >> 2)) begin
          errs++;
          $display("FAIL sb_instr: got %h want %h", if_instr, 32'h1000_0000 + 32'(exp_pc >> 2));
        end
        vecs++;
        if (if_pc_four !== 32'(exp_pc) + 32'd4) begin
          errs++;
          $display("FAIL sb_pc_four: got %h want %h", if_pc_four, 32'(exp_pc) + 32'd4);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [PC_W-1:0] start, input int n);
    sb.delete();
    for (int i = 0; i < n; i++) sb.push_back(start + PC_W'(4 * i));
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_sel = 1'b0; br_pc = '0; if_ready = 1'b1;
    cycle(); cycle();
    vecs++;
    if (if_valid !== 1'b0 || if_pc !== '0 || if_instr !== '0) begin
      errs++;
      $display("FAIL reset_out: got v=%b pc=%h instr=%h want 0/0/0", if_valid, if_pc, if_instr);
    end
    vecs++;
    if (imem_addr !== '0 || flush !== 1'b0) begin
      errs++;
      $display("FAIL reset_addr: got addr=%h flush=%b want 0/0", imem_addr, flush);
    end
    push_seq('0, 24);
    reset = 1'b0;
    #1;
    vecs++;
    if (imem_addr !== 9'h000) begin errs++; $display("FAIL boot_addr_c0: got %h want 000", imem_addr); end
    cycle();
    vecs++;
    if (if_valid !== 1'b0 || imem_addr !== 9'h000) begin
      errs++; $display("FAIL boot_c1: got v=%b addr=%h want 0/000", if_valid, imem_addr);
    end
    cycle();
    vecs++;
    if (if_valid !== 1'b0 || imem_addr !== 9'h004) begin
      errs++; $display("FAIL boot_c2: got v=%b addr=%h want 0/004", if_valid, imem_addr);
    end
    cycle();
    vecs++;
    if (if_valid !== 1'b1 || if_pc !== 9'h000 || if_pc_four !== 32'h4 || imem_addr !== 9'h008) begin
      errs++;
      $display("FAIL first_valid_c3: got v=%b pc=%h four=%h addr=%h want 1/000/4/008",
               if_valid, if_pc, if_pc_four, imem_addr);
    end
  endtask

  task automatic test_stream();
    bit found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      cycle();
      vecs++;
      if (if_valid !== 1'b1) begin errs++; $display("FAIL stream_bubble: got v=%b want 1", if_valid); end
      if (if_pc == 9'h010) found = 1'b1;
    end
    vecs++;
    if (!found) begin errs++; $display("FAIL stream_timeout: got no pc 010 want pc 010"); end
  endtask

  task automatic test_stall();
    logic [PC_W-1:0] ahead;
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vecs++;
      if (if_valid !== 1'b1 || if_pc !== 9'h010 || if_instr !== 32'h1000_0004 || if_pc_four !== 32'h14) begin
        errs++;
        $display("FAIL stall_hold: got v=%b pc=%h instr=%h four=%h want 1/010/10000004/14",
                 if_valid, if_pc, if_instr, if_pc_four);
      end
      ahead = imem_addr - if_pc;
      vecs++;
      if (ahead > 9'd8) begin errs++; $display("FAIL stall_ahead: got %0d bytes want <=8", ahead); end
    end
    if_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      vecs++;
      if (if_valid !== 1'b1 || if_pc !== 9'h010 + PC_W'(4 * k)) begin
        errs++;
        $display("FAIL stall_release: got v=%b pc=%h want 1/%h", if_valid, if_pc, 9'h010 + PC_W'(4 * k));
      end
    end
  endtask

  task automatic test_redirect();
    pc_sel = 1'b1; br_pc = 32'h0000_0103;
    #1;
    vecs++;
    if (flush !== 1'b1) begin errs++; $display("FAIL redir_flush: got %b want 1", flush); end
    cycle();
    pc_sel = 1'b0; br_pc = '0;
    push_seq(9'h100, 8);
    #1;
    vecs++;
    if (flush !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 9'h100) begin
      errs++;
      $display("FAIL redir_n1: got flush=%b v=%b addr=%h want 0/0/100", flush, if_valid, imem_addr);
    end
    cycle();
    vecs++;
    if (if_valid !== 1'b0) begin errs++; $display("FAIL redir_n2: got v=%b want 0", if_valid); end
    cycle();
    vecs++;
    if (if_valid !== 1'b1 || if_pc !== 9'h100) begin
      errs++; $display("FAIL redir_n3: got v=%b pc=%h want 1/100", if_valid, if_pc);
    end
    cycle();
    vecs++;
    if (if_valid !== 1'b1 || if_pc !== 9'h104) begin
      errs++; $display("FAIL redir_n4: got v=%b pc=%h want 1/104", if_valid, if_pc);
    end
  endtask

  task automatic test_redirect_skid();
    if_ready = 1'b0;
    cycle(); cycle(); cycle();
    pc_sel = 1'b1; br_pc = 32'h0000_0040;
    #1;
    vecs++;
    if (flush !== 1'b1 || if_valid !== 1'b1) begin
      errs++; $display("FAIL skid_redir_n: got flush=%b v=%b want 1/1", flush, if_valid);
    end
    cycle();
    pc_sel = 1'b0; if_ready = 1'b1;
    push_seq(9'h040, 8);
    #1;
    vecs++;
    if (if_valid !== 1'b0) begin errs++; $display("FAIL skid_redir_n1: got v=%b want 0", if_valid); end
    cycle();
    vecs++;
    if (if_valid !== 1'b0) begin errs++; $display("FAIL skid_redir_n2: got v=%b want 0", if_valid); end
    cycle();
    vecs++;
    if (if_valid !== 1'b1 || if_pc !== 9'h040) begin
      errs++; $display("FAIL skid_redir_n3: got v=%b pc=%h want 1/040", if_valid, if_pc);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    pc_sel = 1'b1; br_pc = 32'h0000_0080;
    cycle();
    br_pc = 32'h0000_00C0;
    #1;
    vecs++;
    if (flush !== 1'b1 || if_valid !== 1'b0) begin
      errs++; $display("FAIL b2b_n1: got flush=%b v=%b want 1/0", flush, if_valid);
    end
    cycle();
    pc_sel = 1'b0;
    push_seq(9'h0C0, 8);
    #1;
    vecs++;
    if (if_valid !== 1'b0 || imem_addr !== 9'h0C0) begin
      errs++; $display("FAIL b2b_n2: got v=%b addr=%h want 0/0c0", if_valid, imem_addr);
    end
    cycle();
    vecs++;
    if (if_valid !== 1'b0) begin errs++; $display("FAIL b2b_n3: got v=%b want 0", if_valid); end
    cycle();
    vecs++;
    if (if_valid !== 1'b1 || if_pc !== 9'h0C0) begin
      errs++; $display("FAIL b2b_n4: got v=%b pc=%h want 1/0c0", if_valid, if_pc);
    end
    cycle();
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] exp_pc;
    pc_sel = 1'b1; br_pc = 32'h0000_01F0;
    cycle();
    pc_sel = 1'b0;
    push_seq(9'h1F0, 8);
    cycle(); cycle();
    for (int k = 0; k < 6; k++) begin
      exp_pc = 9'h1F0 + PC_W'(4 * k);
      vecs++;
      if (if_valid !== 1'b1 || if_pc !== exp_pc) begin
        errs++; $display("FAIL wrap_seq: got v=%b pc=%h want 1/%h", if_valid, if_pc, exp_pc);
      end
      if (exp_pc == 9'h1FC) begin
        vecs++;
        if (if_pc_four !== 32'h0000_0200) begin
          errs++; $display("FAIL wrap_pc_four: got %h want 00000200", if_pc_four);
        end
      end
      cycle();
    end
  endtask

  task automatic test_reset_mid();
    #2;
    reset = 1'b1;
    #1;
    vecs++;
    if (if_valid !== 1'b0 || if_pc !== '0 || if_instr !== '0 || imem_addr !== '0) begin
      errs++;
      $display("FAIL reset_mid: got v=%b pc=%h instr=%h addr=%h want 0/0/0/0",
               if_valid, if_pc, if_instr, imem_addr);
    end
    cycle(); cycle();
    push_seq('0, 8);
    reset = 1'b0;
    cycle(); cycle();
    vecs++;
    if (if_valid !== 1'b0) begin errs++; $display("FAIL reset_mid_c2: got v=%b want 0", if_valid); end
    cycle();
    vecs++;
    if (if_valid !== 1'b1 || if_pc !== 9'h000) begin
      errs++; $display("FAIL reset_mid_c3: got v=%b pc=%h want 1/000", if_valid, if_pc);
    end
    cycle(); cycle();
  endtask

`ifdef FETCH_REDIRECT_CNT_EN
  task automatic test_redirect_cnt();
    vecs++;
    if (redirect_cnt !== 16'd0) begin errs++; $display("FAIL cnt_reset: got %h want 0000", redirect_cnt); end
    pc_sel = 1'b1; br_pc = 32'h0000_0020;
    cycle();
    pc_sel = 1'b0;
    cycle();
    pc_sel = 1'b1; br_pc = 32'h0000_0060;
    cycle();
    br_pc = 32'h0000_0070;
    cycle();
    pc_sel = 1'b0;
    push_seq(9'h070, 8);
    #1;
    vecs++;
    if (redirect_cnt !== 16'd3) begin errs++; $display("FAIL cnt_three: got %0d want 3", redirect_cnt); end
    cycle(); cycle();
    vecs++;
    if (if_valid !== 1'b1 || if_pc !== 9'h070) begin
      errs++; $display("FAIL cnt_last_target: got v=%b pc=%h want 1/070", if_valid, if_pc);
    end
    pc_sel = 1'b1; br_pc = '0;
    repeat (65531) cycle();
    pc_sel = 1'b0;
    #1;
    vecs++;
    if (redirect_cnt !== 16'hFFFE) begin errs++; $display("FAIL cnt_preload: got %h want fffe", redirect_cnt); end
    pc_sel = 1'b1;
    repeat (3) cycle();
    pc_sel = 1'b0;
    #1;
    vecs++;
    if (redirect_cnt !== 16'hFFFF) begin errs++; $display("FAIL cnt_saturate: got %h want ffff", redirect_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_skid();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
`ifdef FETCH_REDIRECT_CNT_EN
    test_redirect_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
